// File: rtl/data_mem_pkg.sv
// Shared constants and byte-address helpers for the dual-port data memory.
// Build option DATA_MEM_FWD_EN (see data_mem_rd_port) enables write-to-read forwarding.
package data_mem_pkg;

    localparam int WORD_W        = 32;
    localparam int DEFAULT_DEPTH = 256;

    // Word index of a byte address: drop the byte offset, wrap modulo depth.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned depth);
        return (byte_addr >> 2) & (depth - 1);
    endfunction

endpackage

// File: rtl/data_mem_rd_port.sv
// One read port: enable/reset gating of the stored word, plus same-cycle
// write forwarding when DATA_MEM_FWD_EN is defined.
module data_mem_rd_port
    import data_mem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              rst_n,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] mem_rdata,
`ifdef DATA_MEM_FWD_EN
    input  logic              we1,
    input  logic [AW-1:0]     idx1,
    input  logic [WORD_W-1:0] wd1,
    input  logic              we2,
    input  logic [AW-1:0]     idx2,
    input  logic [WORD_W-1:0] wd2,
`endif
    output logic [WORD_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if (rst_n && re) begin
            rdata = mem_rdata;
`ifdef DATA_MEM_FWD_EN
            // Port 2 is checked last so it wins, matching the write collision rule.
            if (we1 && (idx1 == idx)) rdata = wd1;
            if (we2 && (idx2 == idx)) rdata = wd2;
`endif
        end
    end

endmodule

// File: rtl/data_mem_dual.sv
// Dual-port word data memory: synchronous writes, combinational gated reads.
// Define DATA_MEM_FWD_EN to forward same-cycle write data to the read ports.
module data_mem_dual
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RE1,
    input  logic              RE2,
    input  logic              WE1,
    input  logic              WE2,
    input  logic [WORD_W-1:0] A1,
    input  logic [WORD_W-1:0] A2,
    input  logic [WORD_W-1:0] WD1,
    input  logic [WORD_W-1:0] WD2,
    output logic [WORD_W-1:0] RD1,
    output logic [WORD_W-1:0] RD2
);

    logic [AW-1:0]     idx1;
    logic [AW-1:0]     idx2;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    assign idx1 = AW'(word_index(A1, DEPTH));
    assign idx2 = AW'(word_index(A2, DEPTH));

    // Port 2 is applied after port 1, so it wins a same-word collision.
    always_comb begin
        mem_d = mem_q;
        if (WE1) mem_d[idx1] = WD1;
        if (WE2) mem_d[idx2] = WD2;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    data_mem_rd_port #(.AW(AW)) u_rd1 (
        .rst_n     (Rst_n),
        .re        (RE1),
        .idx       (idx1),
        .mem_rdata (mem_q[idx1]),
`ifdef DATA_MEM_FWD_EN
        .we1       (WE1),
        .idx1      (idx1),
        .wd1       (WD1),
        .we2       (WE2),
        .idx2      (idx2),
        .wd2       (WD2),
`endif
        .rdata     (RD1)
    );

    data_mem_rd_port #(.AW(AW)) u_rd2 (
        .rst_n     (Rst_n),
        .re        (RE2),
        .idx       (idx2),
        .mem_rdata (mem_q[idx2]),
`ifdef DATA_MEM_FWD_EN
        .we1       (WE1),
        .idx1      (idx1),
        .wd1       (WD1),
        .we2       (WE2),
        .idx2      (idx2),
        .wd2       (WD2),
`endif
        .rdata     (RD2)
    );

endmodule

// File: tb/tb_data_mem_dual.sv
// Directed bench for data_mem_dual: reset, dual write/read, gating, collision,
// address wrap, read-during-write and back-to-back traffic.
module tb_data_mem_dual;

    localparam int DEPTH = 256;

    logic        Clk;
    logic        Rst_n;
    logic        RE1, RE2, WE1, WE2;
    logic [31:0] A1, A2, WD1, WD2;
    logic [31:0] RD1, RD2;

    int tests;
    int fails;

    data_mem_dual #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .RE1   (RE1),
        .RE2   (RE2),
        .WE1   (WE1),
        .WE2   (WE2),
        .A1    (A1),
        .A2    (A2),
        .WD1   (WD1),
        .WD2   (WD2),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RE1 = 1'b0; RE2 = 1'b0; WE1 = 1'b0; WE2 = 1'b0;
        A1 = '0; A2 = '0; WD1 = '0; WD2 = '0;
    endtask

    task automatic test_reset();
        idle();
        Rst_n = 1'b0;
        RE1 = 1'b1; RE2 = 1'b1; A1 = 32'h0; A2 = 32'h4;
        #2;
        tests++;
        if (RD1 !== 32'h0) begin
            fails++; $display("FAIL reset_rd1: got %h expected %h", RD1, 32'h0);
        end
        tests++;
        if (RD2 !== 32'h0) begin
            fails++; $display("FAIL reset_rd2: got %h expected %h", RD2, 32'h0);
        end
        repeat (2) tick();
        Rst_n = 1'b1;
        tick();
        #1;
        tests++;
        if (RD1 !== 32'h0) begin
            fails++; $display("FAIL reset_word0: got %h expected %h", RD1, 32'h0);
        end
        idle();
    endtask

    task automatic test_dual_write();
        WE1 = 1'b1; WE2 = 1'b1;
        A1 = 32'h0; WD1 = 32'hFFFF6969; A2 = 32'h4;   WD2 = 32'h6969FFFF;
        tick();
        A1 = 32'h8; WD1 = 32'h42042069; A2 = 32'h100; WD2 = 32'h7777777F;
        tick();
        WE1 = 1'b0; WE2 = 1'b0; RE1 = 1'b1; RE2 = 1'b1;
        A1 = 32'h0; A2 = 32'h4;
        #1;
        tests++;
        if (RD1 !== 32'hFFFF6969) begin
            fails++; $display("FAIL dual_rd1_a: got %h expected %h", RD1, 32'hFFFF6969);
        end
        tests++;
        if (RD2 !== 32'h6969FFFF) begin
            fails++; $display("FAIL dual_rd2_a: got %h expected %h", RD2, 32'h6969FFFF);
        end
        A1 = 32'h8; A2 = 32'h100;
        #1;
        tests++;
        if (RD1 !== 32'h42042069) begin
            fails++; $display("FAIL dual_rd1_b: got %h expected %h", RD1, 32'h42042069);
        end
        tests++;
        if (RD2 !== 32'h7777777F) begin
            fails++; $display("FAIL dual_rd2_b: got %h expected %h", RD2, 32'h7777777F);
        end
        idle();
    endtask

    task automatic test_no_overwrite();
        WE1 = 1'b0; WE2 = 1'b0;
        A1 = 32'h0; WD1 = 32'h12345678; A2 = 32'h4; WD2 = 32'hFFFFFFFF;
        tick();
        tick();
        RE1 = 1'b1; RE2 = 1'b1;
        #1;
        tests++;
        if (RD1 !== 32'hFFFF6969) begin
            fails++; $display("FAIL no_overwrite_rd1: got %h expected %h", RD1, 32'hFFFF6969);
        end
        tests++;
        if (RD2 !== 32'h6969FFFF) begin
            fails++; $display("FAIL no_overwrite_rd2: got %h expected %h", RD2, 32'h6969FFFF);
        end
        idle();
    endtask

    task automatic test_read_gating();
        RE1 = 1'b0; RE2 = 1'b0; A1 = 32'h8; A2 = 32'h100;
        #1;
        tests++;
        if (RD1 !== 32'h0) begin
            fails++; $display("FAIL gate_off_rd1: got %h expected %h", RD1, 32'h0);
        end
        tests++;
        if (RD2 !== 32'h0) begin
            fails++; $display("FAIL gate_off_rd2: got %h expected %h", RD2, 32'h0);
        end
        RE1 = 1'b1; RE2 = 1'b1;
        #1;
        tests++;
        if (RD1 !== 32'h42042069) begin
            fails++; $display("FAIL gate_on_rd1: got %h expected %h", RD1, 32'h42042069);
        end
        tests++;
        if (RD2 !== 32'h7777777F) begin
            fails++; $display("FAIL gate_on_rd2: got %h expected %h", RD2, 32'h7777777F);
        end
        idle();
        tick();
    endtask

    task automatic test_collision_wrap();
        WE1 = 1'b1; WE2 = 1'b1;
        A1 = 32'h10; WD1 = 32'h11111111; A2 = 32'h10; WD2 = 32'h22222222;
        tick();
        idle();
        RE1 = 1'b1; RE2 = 1'b1; A1 = 32'h10; A2 = 32'h13;
        #1;
        tests++;
        if (RD1 !== 32'h22222222) begin
            fails++; $display("FAIL collision_rd1: got %h expected %h", RD1, 32'h22222222);
        end
        tests++;
        if (RD2 !== 32'h22222222) begin
            fails++; $display("FAIL collision_rd2_offset: got %h expected %h", RD2, 32'h22222222);
        end
        idle();
        WE1 = 1'b1; A1 = DEPTH * 4 + 32'hC; WD1 = 32'h5EED0C0C;
        tick();
        idle();
        RE2 = 1'b1; A2 = 32'hC;
        #1;
        tests++;
        if (RD2 !== 32'h5EED0C0C) begin
            fails++; $display("FAIL wrap_rd2: got %h expected %h", RD2, 32'h5EED0C0C);
        end
        idle();
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp_now;
`ifdef DATA_MEM_FWD_EN
        exp_now = 32'hA5A5A5A5;
`else
        exp_now = 32'hFFFF6969;
`endif
        RE1 = 1'b1; A1 = 32'h0;
        WE2 = 1'b1; A2 = 32'h0; WD2 = 32'hA5A5A5A5;
        #1;
        tests++;
        if (RD1 !== exp_now) begin
            fails++; $display("FAIL rdw_before_edge: got %h expected %h", RD1, exp_now);
        end
        tick();
        WE2 = 1'b0;
        #1;
        tests++;
        if (RD1 !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL rdw_after_edge: got %h expected %h", RD1, 32'hA5A5A5A5);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            WE1 = 1'b1; WE2 = 1'b1;
            A1 = 32'h40 + i * 8; WD1 = 32'hC0DE0000 + i;
            A2 = 32'h44 + i * 8; WD2 = 32'hBEEF0000 + i;
            tick();
        end
        idle();
        RE1 = 1'b1; RE2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A1 = 32'h40 + i * 8; A2 = 32'h44 + i * 8;
            #1;
            tests++;
            if (RD1 !== 32'hC0DE0000 + i) begin
                fails++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", i, RD1, 32'hC0DE0000 + i);
            end
            tests++;
            if (RD2 !== 32'hBEEF0000 + i) begin
                fails++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", i, RD2, 32'hBEEF0000 + i);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        RE1 = 1'b1; RE2 = 1'b1; A1 = 32'h0; A2 = 32'h8;
        Rst_n = 1'b0;
        #1;
        tests++;
        if (RD1 !== 32'h0) begin
            fails++; $display("FAIL mid_reset_rd1: got %h expected %h", RD1, 32'h0);
        end
        tests++;
        if (RD2 !== 32'h0) begin
            fails++; $display("FAIL mid_reset_rd2: got %h expected %h", RD2, 32'h0);
        end
        WE1 = 1'b1; WD1 = 32'h13579BDF;
        tick();
        WE1 = 1'b0;
        Rst_n = 1'b1;
        tick();
        #1;
        tests++;
        if (RD1 !== 32'h0) begin
            fails++; $display("FAIL mid_reset_word0: got %h expected %h", RD1, 32'h0);
        end
        tests++;
        if (RD2 !== 32'h0) begin
            fails++; $display("FAIL mid_reset_word2: got %h expected %h", RD2, 32'h0);
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_dual_write();
        test_no_overwrite();
        test_read_gating();
        test_collision_wrap();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
